mod11_operand_sequencer: RTL and testbench

- Sequential front-end for the combinational mod-11 adder/subtractor stage (inputs s, x[3:0], y[3:0]; output z[3:0]).
- Accepts an op nibble and operand digits one at a time over a valid/ready nibble bus.
- Range-checks the operands, then drives them stably into the adder and registers its z result.
- Returns the result on a valid/ready output, with a chain mode that reuses the previous result as x.

---
 rtl/mod11_operand_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_mod11_operand_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod11_operand_sequencer.sv
// Sequencing front-end for a combinational mod-11 add/subtract stage: it collects an op
// and its digits over a nibble bus, holds them on the adder, and returns the registered result.
`timescale 1ns/1ps
module mod11_operand_sequencer #(
    parameter int MODULUS       = 11,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic [3:0] add_x,
    output logic [3:0] add_y,
    output logic       add_s,
    input  logic [3:0] add_z,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       err,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_X   = 3'd1,
        ST_GET_Y   = 3'd2,
        ST_DRIVE   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_OUT     = 3'd5
    } state_t;

    localparam logic [3:0] MOD_L    = 4'(MODULUS);
    localparam logic [3:0] SETTLE_L = 4'(SETTLE_CYCLES);

    function automatic logic in_range_f(input logic [3:0] d);
        return (d < MOD_L);
    endfunction

    state_t     state_r, state_s;
    logic       in_ready_r, in_ready_s;
    logic [3:0] add_x_r, add_x_s;
    logic [3:0] add_y_r, add_y_s;
    logic       add_s_r, add_s_s;
    logic [3:0] cnt_r, cnt_s;
    logic       res_valid_r, res_valid_s;
    logic [3:0] res_data_r, res_data_s;
    logic [3:0] chain_r, chain_s;
    logic       err_r, err_s;
    logic [1:0] err_code_r, err_code_s;
    logic       in_xfer_s;

    assign in_xfer_s = in_valid && in_ready_r;

    // Next-state and next-register computation for the operand sequence
    always_comb begin
        state_s     = state_r;
        add_x_s     = add_x_r;
        add_y_s     = add_y_r;
        add_s_s     = add_s_r;
        cnt_s       = cnt_r;
        res_valid_s = res_valid_r;
        res_data_s  = res_data_r;
        chain_s     = chain_r;
        err_s       = 1'b0;
        err_code_s  = err_code_r;
        case (state_r)
            ST_IDLE: begin
                if (in_xfer_s) begin
                    if (in_data[3:2] != 2'b00) begin
                        err_s      = 1'b1;
                        err_code_s = 2'd1;
                    end else if (in_data[1]) begin
                        add_s_s = in_data[0];
                        add_x_s = chain_r;
                        state_s = ST_GET_Y;
                    end else begin
                        add_s_s = in_data[0];
                        state_s = ST_GET_X;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GET_X: begin
                if (in_xfer_s) begin
                    if (in_range_f(in_data)) begin
                        add_x_s = in_data;
                        state_s = ST_GET_Y;
                    end else begin
                        err_s      = 1'b1;
                        err_code_s = 2'd2;
                        state_s    = ST_IDLE;
                    end
                end else begin
                    state_s = ST_GET_X;
                end
            end
            ST_GET_Y: begin
                if (in_xfer_s) begin
                    if (in_range_f(in_data)) begin
                        add_y_s = in_data;
                        cnt_s   = SETTLE_L;
                        state_s = ST_DRIVE;
                    end else begin
                        err_s      = 1'b1;
                        err_code_s = 2'd2;
                        state_s    = ST_IDLE;
                    end
                end else begin
                    state_s = ST_GET_Y;
                end
            end
            ST_DRIVE: begin
                // A zero count is treated like one so a corrupted counter cannot stall here
                if (cnt_r <= 4'd1) begin
                    cnt_s   = 4'd0;
                    state_s = ST_CAPTURE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_CAPTURE: begin
                if (in_range_f(add_z)) begin
                    res_data_s  = add_z;
                    chain_s     = add_z;
                    res_valid_s = 1'b1;
                    state_s     = ST_OUT;
                end else begin
                    err_s      = 1'b1;
                    err_code_s = 2'd3;
                    state_s    = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (res_ready) begin
                    res_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                res_valid_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
        in_ready_s = (state_s == ST_IDLE) || (state_s == ST_GET_X) || (state_s == ST_GET_Y);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            add_x_r     <= 4'd0;
            add_y_r     <= 4'd0;
            add_s_r     <= 1'b0;
            cnt_r       <= 4'd0;
            res_valid_r <= 1'b0;
            res_data_r  <= 4'd0;
            chain_r     <= 4'd0;
            err_r       <= 1'b0;
            err_code_r  <= 2'd0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= in_ready_s;
            add_x_r     <= add_x_s;
            add_y_r     <= add_y_s;
            add_s_r     <= add_s_s;
            cnt_r       <= cnt_s;
            res_valid_r <= res_valid_s;
            res_data_r  <= res_data_s;
            chain_r     <= chain_s;
            err_r       <= err_s;
            err_code_r  <= err_code_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign add_x     = add_x_r;
    assign add_y     = add_y_r;
    assign add_s     = add_s_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign err       = err_r;
    assign err_code  = err_code_r;

endmodule

// File: tb/tb_mod11_operand_sequencer.sv
// Directed bench for mod11_operand_sequencer with a behavioural mod-11 adder on add_x/add_y/add_s.
`timescale 1ns/1ps
module tb_mod11_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'd0;
    logic [3:0] add_x, add_y, add_z;
    logic       add_s;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_data;
    logic       err;
    logic [1:0] err_code;

    logic       force_z_en = 1'b0;
    logic [3:0] force_z_val = 4'd0;
    int         checks = 0;
    int         passes = 0;
    int         err_cnt = 0;
    int         xfer_cnt = 0;

    mod11_operand_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .add_x(add_x), .add_y(add_y), .add_s(add_s), .add_z(add_z),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Environment model of the combinational adder stage (true modulo, with fault injection)
    always_comb begin
        int sx, sy, r;
        sx = int'(add_x);
        sy = int'(add_y);
        r  = add_s ? ((sx - sy + 11) % 11) : ((sx + sy) % 11);
        add_z = force_z_en ? force_z_val : 4'(r);
    end

    always @(posedge clk) begin
        if (err) err_cnt <= err_cnt + 1;
        if (res_valid && res_ready) xfer_cnt <= xfer_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [3:0] d);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        else passes++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [3:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        d = res_valid ? res_data : 4'bxxxx;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({in_ready, res_valid, err, err_code} !== 5'b1_0_0_00)
            $display("FAIL reset_ctrl: got %b required 10000", {in_ready, res_valid, err, err_code}); else passes++;
        checks++; if ({add_x, add_y, add_s, res_data} !== 13'd0)
            $display("FAIL reset_data: got %h required 0", {add_x, add_y, add_s, res_data}); else passes++;
    endtask

    task automatic test_add();
        int e0;
        e0 = err_cnt;
        send(4'h0); send(4'd7); send(4'd5);
        @(negedge clk);
        checks++; if ({add_x, add_y, add_s} !== {4'd7, 4'd5, 1'b0})
            $display("FAIL add_operands: got %h/%h/%b required 7/5/0", add_x, add_y, add_s); else passes++;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0)
            $display("FAIL add_latency_early: res_valid=%b required 0", res_valid); else passes++;
        @(negedge clk);
        checks++; if (res_valid !== 1'b1 || res_data !== 4'd1)
            $display("FAIL add_latency: res_valid=%b res_data=%0d required 1/1", res_valid, res_data); else passes++;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL add_release: res_valid=%b in_ready=%b required 0/1", res_valid, in_ready); else passes++;
        checks++; if (err_cnt !== e0)
            $display("FAIL add_no_err: err pulses=%0d required %0d", err_cnt, e0); else passes++;
    endtask

    task automatic test_subtract();
        logic [3:0] r;
        send(4'h1); send(4'd3); send(4'd8); wait_result(r);
        checks++; if (r !== 4'd6) $display("FAIL sub_3_8: got %0d required 6", r); else passes++;
        send(4'h1); send(4'd10); send(4'd10); wait_result(r);
        checks++; if (r !== 4'd0) $display("FAIL sub_10_10: got %0d required 0", r); else passes++;
        send(4'h0); send(4'd10); send(4'd10); wait_result(r);
        checks++; if (r !== 4'd9) $display("FAIL add_10_10: got %0d required 9", r); else passes++;
    endtask

    task automatic test_chain();
        logic [3:0] r;
        send(4'h0); send(4'd7); send(4'd5); wait_result(r);
        checks++; if (r !== 4'd1) $display("FAIL chain_seed: got %0d required 1", r); else passes++;
        send(4'h3); send(4'd4);
        checks++; if ({add_x, add_y, add_s} !== {4'd1, 4'd4, 1'b1})
            $display("FAIL chain_operands: got %h/%h/%b required 1/4/1", add_x, add_y, add_s); else passes++;
        wait_result(r);
        checks++; if (r !== 4'd8) $display("FAIL chain_result: got %0d required 8", r); else passes++;
    endtask

    task automatic test_errors();
        logic [3:0] r;
        int x0;
        x0 = xfer_cnt;
        send(4'h0); send(4'd12);
        checks++; if (err !== 1'b1 || err_code !== 2'd2)
            $display("FAIL err_digit_x: err=%b code=%0d required 1/2", err, err_code); else passes++;
        @(posedge clk);
        #1;
        checks++; if (err !== 1'b0 || err_code !== 2'd2 || in_ready !== 1'b1 || res_valid !== 1'b0)
            $display("FAIL err_digit_after: err=%b code=%0d rdy=%b vld=%b required 0/2/1/0", err, err_code, in_ready, res_valid);
        else passes++;
        send(4'h0); send(4'd3); send(4'd11);
        checks++; if (err !== 1'b1 || err_code !== 2'd2)
            $display("FAIL err_digit_y11: err=%b code=%0d required 1/2", err, err_code); else passes++;
        send(4'h4);
        checks++; if (err !== 1'b1 || err_code !== 2'd1)
            $display("FAIL err_bad_op: err=%b code=%0d required 1/1", err, err_code); else passes++;
        checks++; if (xfer_cnt !== x0)
            $display("FAIL err_no_result: transfers=%0d required %0d", xfer_cnt, x0); else passes++;
        send(4'h0); send(4'd7); send(4'd5); wait_result(r);
        force_z_en = 1'b1; force_z_val = 4'd13;
        send(4'h0); send(4'd2); send(4'd3);
        repeat (3) @(negedge clk);
        checks++; if (err !== 1'b1 || err_code !== 2'd3 || res_valid !== 1'b0)
            $display("FAIL err_adder: err=%b code=%0d vld=%b required 1/3/0", err, err_code, res_valid); else passes++;
        force_z_en = 1'b0;
        send(4'h2); send(4'd4);
        checks++; if (add_x !== 4'd1) $display("FAIL err_chain_kept: add_x=%0d required 1", add_x); else passes++;
        wait_result(r);
        checks++; if (r !== 4'd5) $display("FAIL err_chain_result: got %0d required 5", r); else passes++;
    endtask

    task automatic test_backpressure();
        int n, x0;
        send(4'h0); send(4'd2); send(4'd3);
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        x0 = xfer_cnt;
        in_valid = 1'b1; in_data = 4'h0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (res_valid !== 1'b1 || res_data !== 4'd5 || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d: vld=%b data=%0d rdy=%b required 1/5/0", i, res_valid, res_data, in_ready);
            else passes++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1 || xfer_cnt !== x0 + 1)
            $display("FAIL bp_release: vld=%b rdy=%b transfers=%0d required 0/1/%0d", res_valid, in_ready, xfer_cnt, x0 + 1);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [3:0] r;
        send(4'h0); send(4'd7); send(4'd5);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if ({in_ready, res_valid, err, err_code} !== 5'b1_0_0_00)
            $display("FAIL rst_mid_ctrl: got %b required 10000", {in_ready, res_valid, err, err_code}); else passes++;
        checks++; if ({add_x, add_y, add_s, res_data} !== 13'd0)
            $display("FAIL rst_mid_data: got %h required 0", {add_x, add_y, add_s, res_data}); else passes++;
        send(4'h2); send(4'd6);
        checks++; if (add_x !== 4'd0) $display("FAIL rst_chain_x: add_x=%0d required 0", add_x); else passes++;
        wait_result(r);
        checks++; if (r !== 4'd6) $display("FAIL rst_chain_result: got %0d required 6", r); else passes++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_subtract();
        test_chain();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
